// File: rtl/act_lut_pkg.sv
// act_lut_pkg: widths, index helpers and sample type shared by the
// LUT fetch stage and the downstream interpolator.
package act_lut_pkg;

    localparam int DATA_W = 8;
    localparam int FRAC_W = 4;
    localparam int IDX_W  = DATA_W - FRAC_W;
    localparam int DEPTH  = 2 ** IDX_W;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic [IDX_W-1:0]         idx_t;
    typedef logic [FRAC_W-1:0]        frac_t;

    typedef struct packed {
        idx_t  idx;
        frac_t frac;
    } s1_t;

    // Arithmetic shift plus half-depth offset equals the integer field
    // taken as offset-binary, so a plain add mod DEPTH is enough.
    function automatic idx_t x_to_idx(sample_t x);
        return x[DATA_W-1:FRAC_W] + idx_t'(DEPTH / 2);
    endfunction

    function automatic idx_t idx_next(idx_t i);
        return (i == idx_t'(DEPTH - 1)) ? i : i + idx_t'(1);
    endfunction

endpackage

// File: rtl/act_lut_table.sv
// act_lut_table: DEPTH x DATA_W register array, one write port and
// two combinational read ports; reads see the pre-write contents.
module act_lut_table
    import act_lut_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    we,
    input  idx_t    waddr,
    input  sample_t wdata,
    input  idx_t    raddr_a,
    output sample_t rdata_a,
    input  idx_t    raddr_b,
    output sample_t rdata_b
);

    sample_t mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/act_lut_fetch.sv
// act_lut_fetch: two-stage index split and LUT read ahead of the interpolator.
// Optional `ACT_LUT_CNT_EN adds a saturating output-transfer counter (xfer_cnt).
module act_lut_fetch
    import act_lut_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  sample_t     in_x,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        tbl_we,
    input  idx_t        tbl_addr,
    input  sample_t     tbl_wdata,
    output sample_t     base,
    output sample_t     next_data,
    output sample_t     remaining,
    output logic        out_valid,
    input  logic        out_ready
`ifdef ACT_LUT_CNT_EN
    ,
    output logic [15:0] xfer_cnt
`endif
);

    logic    s1_valid;
    s1_t     s1;
    logic    s2_load;
    sample_t rd_base;
    sample_t rd_next;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    act_lut_table u_table (
        .clk     (clk),
        .rst     (rst),
        .we      (tbl_we),
        .waddr   (tbl_addr),
        .wdata   (tbl_wdata),
        .raddr_a (s1.idx),
        .rdata_a (rd_base),
        .raddr_b (idx_next(s1.idx)),
        .rdata_b (rd_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1.idx  <= x_to_idx(in_x);
                s1.frac <= in_x[FRAC_W-1:0];
            end
        end
    end

    // Data regs only move with a real item so a drained stage keeps its last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            base      <= '0;
            next_data <= '0;
            remaining <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                base      <= rd_base;
                next_data <= rd_next;
                remaining <= sample_t'({{(DATA_W-FRAC_W){1'b0}}, s1.frac});
            end
        end
    end

`ifdef ACT_LUT_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer_cnt <= '0;
        end else if (out_valid && out_ready && xfer_cnt != 16'hFFFF) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_act_lut_fetch.sv
// tb_act_lut_fetch: vector table plus scoreboard bench for act_lut_fetch.
module tb_act_lut_fetch;
    import act_lut_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    sample_t in_x;
    logic    in_valid;
    logic    in_ready;
    logic    tbl_we;
    idx_t    tbl_addr;
    sample_t tbl_wdata;
    sample_t base;
    sample_t next_data;
    sample_t remaining;
    logic    out_valid;
    logic    out_ready;
`ifdef ACT_LUT_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    act_lut_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .in_x      (in_x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_wdata (tbl_wdata),
        .base      (base),
        .next_data (next_data),
        .remaining (remaining),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ACT_LUT_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int eb;
        int en;
        int er;
    } req_t;

    typedef struct {
        logic [7:0] x;
        int         eb;
        int         en;
        int         er;
    } vec_t;

    req_t sbq[$];
    int   pop_cyc[$];
    int   errs   = 0;
    int   nchk   = 0;
    int   cyc    = 0;
    int   n_xfer = 0;
    logic bp_done;

    function automatic req_t mk(input int eb, input int en, input int er);
        req_t r;
        r.eb = eb;
        r.en = en;
        r.er = er;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        nchk++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            n_xfer++;
            if (sbq.size() == 0) begin
                nchk++;
                errs++;
                $display("FAIL extra_output: got base %0d, required no output",
                         int'(base));
            end else begin
                req_t r;
                r = sbq.pop_front();
                chk("base", int'(base), r.eb);
                chk("next_data", int'(next_data), r.en);
                chk("remaining", int'(remaining), r.er);
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic tbl_load();
        for (int i = 0; i < DEPTH; i++) begin
            tbl_we    = 1'b1;
            tbl_addr  = idx_t'(i);
            tbl_wdata = sample_t'(8 * i - 64);
            @(posedge clk);
            #1;
        end
        tbl_we = 1'b0;
    endtask

    task automatic send(input logic [7:0] x, input req_t r);
        in_x     = sample_t'(x);
        in_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
        if (!in_ready) begin
            nchk++;
            errs++;
            $display("FAIL send_timeout: in_ready got 0, required 1");
        end else begin
            sbq.push_back(r);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sbq.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain_empty", sbq.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v[10];
        v[0] = '{8'h25, 16, 24, 5};
        v[1] = '{8'h80, -64, -56, 0};
        v[2] = '{8'h7F, 56, 56, 15};
        v[3] = '{8'h00, 0, 8, 0};
        v[4] = '{8'h10, 8, 16, 0};
        v[5] = '{8'hF0, -8, 0, 0};
        v[6] = '{8'hFF, -8, 0, 15};
        v[7] = '{8'h73, 56, 56, 3};
        v[8] = '{8'h6A, 48, 56, 10};
        v[9] = '{8'h8C, -64, -56, 12};

        rst = 1'b0;
        in_x = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tbl_we = 1'b0;
        tbl_addr = '0;
        tbl_wdata = '0;
        bp_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_base", int'(base), 0);
        chk("rst_next", int'(next_data), 0);
        chk("rst_rem", int'(remaining), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // T1: latency of a single item
        tbl_load();
        in_x = sample_t'(8'h25);
        in_valid = 1'b1;
        chk("t1_in_ready", int'(in_ready), 1);
        sbq.push_back(mk(16, 24, 5));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t1_lat1_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("t1_lat2_valid", int'(out_valid), 1);
        drain();

        // Vector table, no backpressure then random backpressure
        tbl_load();
        for (int i = 0; i < 10; i++) send(v[i].x, mk(v[i].eb, v[i].en, v[i].er));
        drain();
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(v[i].x, mk(v[i].eb, v[i].en, v[i].er));
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // T3: back-to-back stream with no bubbles
        tbl_load();
        pop_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            in_x = sample_t'(8'(i * 16));
            in_valid = 1'b1;
            @(negedge clk);
            chk("t3_in_ready", int'(in_ready), 1);
            sbq.push_back(mk(8 * i, 8 * i + 8, 0));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        chk("t3_pops", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) chk("t3_gap", pop_cyc[2] - pop_cyc[0], 2);

        // T4: full stall with a third item waiting
        tbl_load();
        out_ready = 1'b0;
        send(8'h25, mk(16, 24, 5));
        send(8'h35, mk(24, 32, 5));
        in_x = sample_t'(8'h45);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_in_ready", int'(in_ready), 0);
            chk("t4_out_valid", int'(out_valid), 1);
            chk("t4_base_hold", int'(base), 16);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_in_ready_release", int'(in_ready), 1);
        sbq.push_back(mk(32, 40, 5));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // T5: table write racing an S2 capture
        tbl_load();
        in_x = sample_t'(8'h25);
        in_valid = 1'b1;
        @(negedge clk);
        chk("t5_in_ready_a", int'(in_ready), 1);
        sbq.push_back(mk(16, 24, 5));
        @(posedge clk);
        #1;
        tbl_we = 1'b1;
        tbl_addr = idx_t'(10);
        tbl_wdata = sample_t'(100);
        @(negedge clk);
        chk("t5_in_ready_b", int'(in_ready), 1);
        sbq.push_back(mk(100, 24, 5));
        @(posedge clk);
        #1;
        tbl_we = 1'b0;
        in_valid = 1'b0;
        drain();

        // T6: reset with two items in flight
        tbl_load();
        out_ready = 1'b0;
        send(8'h25, mk(16, 24, 5));
        send(8'h35, mk(24, 32, 5));
        @(negedge clk);
        chk("t6_pre_valid", int'(out_valid), 1);
`ifdef ACT_LUT_CNT_EN
        chk("t6_pre_cnt", int'(xfer_cnt), n_xfer);
`endif
        #1;
        rst = 1'b0;
        #1;
        chk("t6_out_valid", int'(out_valid), 0);
        chk("t6_base", int'(base), 0);
        chk("t6_next", int'(next_data), 0);
        chk("t6_rem", int'(remaining), 0);
        chk("t6_in_ready", int'(in_ready), 1);
`ifdef ACT_LUT_CNT_EN
        chk("t6_cnt", int'(xfer_cnt), 0);
`endif
        sbq.delete();
        n_xfer = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        send(8'h25, mk(0, 0, 5));
        send(8'h7F, mk(0, 0, 15));
        drain();
`ifdef ACT_LUT_CNT_EN
        chk("t6_post_cnt", int'(xfer_cnt), n_xfer);
`endif

        chk("sb_final", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
